matrix_collector: RTL and testbench

//   Write-side counterpart of the matrix ROMs. Captures the skewed per-column output stream of the

---
 rtl/sa_pkg.sv | 14 +
 rtl/mc_column.sv | 61 ++++++
 rtl/matrix_collector.sv | 104 ++++++++++
 tb/tb_matrix_collector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared systolic-array constants and the matrix collector FSM state type.
package sa_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ARRAY_W    = 5;
  localparam int unsigned DEF_ARRAY_L    = 2;

  typedef enum logic [1:0] {
    MC_IDLE    = 2'd0,
    MC_COLLECT = 2'd1,
    MC_DONE    = 2'd2
  } mc_state_t;

endpackage

// File: rtl/mc_column.sv
// One collector lane: row counter, row-select write decode and the column's storage.
module mc_column
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ARRAY_W    = DEF_ARRAY_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  collect,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]    col_data,
  output logic                                  full_c,
  output logic                                  drop_c
);

  localparam int unsigned CNT_W = $clog2(ARRAY_W + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_now;
  logic             wr_c;

  assign full_now = (cnt_q == CNT_W'(ARRAY_W));
  assign wr_c     = collect & in_valid & ~full_now;
  // Anything valid that is not written (wrong state or full column) is a drop.
  assign drop_c   = in_valid & ~clear & ~wr_c;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wr_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fullness after the coming edge, so the FSM can leave COLLECT on the last write.
  assign full_c = (cnt_d == CNT_W'(ARRAY_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      col_data <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clear) begin
        col_data <= '0;
      end else if (wr_c) begin
        for (int i = 0; i < int'(ARRAY_W); i++) begin
          if (cnt_q == CNT_W'(i)) begin
            col_data[i] <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/matrix_collector.sv
// Collects the skewed per-column systolic array output into a [row][col] result matrix.
// Optional sticky drop flag on port overflow when MATRIX_COLLECT_OVF_EN is defined.
module matrix_collector
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ARRAY_W    = DEF_ARRAY_W,
  parameter int unsigned ARRAY_L    = DEF_ARRAY_L
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [0:ARRAY_L-1]                                 in_valid,
  input  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]                 in_data,
  output logic                                               busy,
  output logic                                               done,
  output logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]    data_out
`ifdef MATRIX_COLLECT_OVF_EN
  ,
  output logic                                               overflow
`endif
);

  mc_state_t state_q;
  mc_state_t state_d;
  logic      busy_q;
  logic      done_q;
  logic      collect;

  logic [0:ARRAY_L-1]                               full_c;
  logic [0:ARRAY_L-1]                               drop_c;
  logic [0:ARRAY_L-1][0:ARRAY_W-1][DATA_WIDTH-1:0]  col_data;

  // A start edge restarts collection, so in_valid on that edge is never written.
  assign collect = (state_q == MC_COLLECT) & ~start;

  for (genvar j = 0; j < int'(ARRAY_L); j++) begin : g_col
    mc_column #(
      .DATA_WIDTH (DATA_WIDTH),
      .ARRAY_W    (ARRAY_W)
    ) u_col (
      .clk      (clk),
      .reset    (reset),
      .clear    (start),
      .collect  (collect),
      .in_valid (in_valid[j]),
      .in_data  (in_data[j]),
      .col_data (col_data[j]),
      .full_c   (full_c[j]),
      .drop_c   (drop_c[j])
    );
    for (genvar i = 0; i < int'(ARRAY_W); i++) begin : g_row
      assign data_out[i][j] = col_data[j][i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE:    state_d = MC_IDLE;
      MC_COLLECT: if (&full_c) state_d = MC_DONE;
      MC_DONE:    state_d = MC_DONE;
      default:    state_d = MC_IDLE;
    endcase
    if (start) begin
      state_d = MC_COLLECT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MC_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == MC_COLLECT);
      done_q  <= (state_d == MC_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

`ifdef MATRIX_COLLECT_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (start) begin
      ovf_q <= 1'b0;
    end else if ((state_q != MC_IDLE) && (|drop_c)) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = |drop_c;
`endif

endmodule

// File: tb/tb_matrix_collector.sv
// Directed table-driven bench for matrix_collector (DATA_WIDTH=8, ARRAY_W=5, ARRAY_L=2).
module tb_matrix_collector;

  typedef logic [0:4][0:1][7:0] mat_t;

  typedef struct {
    logic       st;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       eb;
    logic       ed;
    logic       eo;
    logic [1:0] chk;   // 0: none, 1: zero matrix, 2: reference matrix
  } vec_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [0:1]       in_valid;
  logic [0:1][7:0]  in_data;
  logic             busy;
  logic             done;
  mat_t             data_out;
`ifdef MATRIX_COLLECT_OVF_EN
  logic             overflow;
`endif

  int   n_vec;
  int   n_err;
  vec_t vecs[$];
  mat_t ref_m;
  mat_t zero_m;

  matrix_collector #(
    .DATA_WIDTH (8),
    .ARRAY_W    (5),
    .ARRAY_L    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
`ifdef MATRIX_COLLECT_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic st, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1,
                              input logic eb, input logic ed, input logic eo,
                              input logic [1:0] chk);
    vec_t v;
    v.st = st; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.eb = eb; v.ed = ed; v.eo = eo; v.chk = chk;
    vecs.push_back(v);
  endfunction

  task automatic check_flags(input string name, input logic eb, input logic ed);
    n_vec++;
    if (busy !== eb || done !== ed) begin
      n_err++;
      $display("FAIL %s: busy/done got %b/%b expected %b/%b", name, busy, done, eb, ed);
    end
  endtask

  task automatic check_mat(input string name, input mat_t exp_m);
    n_vec++;
    if (data_out !== exp_m) begin
      n_err++;
      $display("FAIL %s: data_out got %h expected %h", name, data_out, exp_m);
    end
  endtask

  task automatic check_ovf(input string name, input logic eo);
`ifdef MATRIX_COLLECT_OVF_EN
    n_vec++;
    if (overflow !== eo) begin
      n_err++;
      $display("FAIL %s: overflow got %b expected %b", name, overflow, eo);
    end
`else
    if (eo === 1'bx) $display("note %s", name);
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    zero_m = '0;
    for (int i = 0; i < 5; i++) begin
      ref_m[i][0] = 8'(i + 1);
      ref_m[i][1] = 8'(i + 11);
    end

    // IDLE: pulses are dropped silently, matrix stays zero
    add(0,1,8'd7 ,1,8'd8 , 0,0,0, 1);
    add(0,0,8'd0 ,0,8'd0 , 0,0,0, 1);
    // skew 1: col0 1..5 on cycles 1..5, col1 11..15 on cycles 2..6
    add(1,0,8'd0 ,0,8'd0 , 1,0,0, 1);
    add(0,1,8'd1 ,0,8'd0 , 1,0,0, 0);
    add(0,1,8'd2 ,1,8'd11, 1,0,0, 0);
    add(0,1,8'd3 ,1,8'd12, 1,0,0, 0);
    add(0,1,8'd4 ,1,8'd13, 1,0,0, 0);
    add(0,1,8'd5 ,1,8'd14, 1,0,0, 0);
    add(0,0,8'd0 ,1,8'd15, 0,1,0, 2);
    // write in DONE is dropped
    add(0,1,8'd99,0,8'd0 , 0,1,1, 2);
    add(0,0,8'd0 ,0,8'd0 , 0,1,1, 2);
    // gaps on col1 (every 3rd cycle); valid on the start edge is ignored
    add(1,1,8'd50,1,8'd60, 1,0,0, 1);
    add(0,1,8'd1 ,1,8'd11, 1,0,0, 0);
    add(0,1,8'd2 ,0,8'd0 , 1,0,0, 0);
    add(0,1,8'd3 ,0,8'd0 , 1,0,0, 0);
    add(0,1,8'd4 ,1,8'd12, 1,0,0, 0);
    add(0,1,8'd5 ,0,8'd0 , 1,0,0, 0);
    add(0,1,8'd77,0,8'd0 , 1,0,1, 0);
    add(0,0,8'd0 ,1,8'd13, 1,0,1, 0);
    add(0,0,8'd0 ,0,8'd0 , 1,0,1, 0);
    add(0,0,8'd0 ,0,8'd0 , 1,0,1, 0);
    add(0,0,8'd0 ,1,8'd14, 1,0,1, 0);
    add(0,0,8'd0 ,0,8'd0 , 1,0,1, 0);
    add(0,0,8'd0 ,0,8'd0 , 1,0,1, 0);
    add(0,0,8'd0 ,1,8'd15, 0,1,1, 2);
    // restart mid-collect after 3 rows, then simultaneous last writes
    add(1,0,8'd0 ,0,8'd0 , 1,0,0, 1);
    add(0,1,8'd1 ,1,8'd11, 1,0,0, 0);
    add(0,1,8'd2 ,1,8'd12, 1,0,0, 0);
    add(0,1,8'd3 ,1,8'd13, 1,0,0, 0);
    add(1,1,8'd9 ,1,8'd9 , 1,0,0, 1);
    add(0,1,8'd1 ,1,8'd11, 1,0,0, 0);
    add(0,1,8'd2 ,1,8'd12, 1,0,0, 0);
    add(0,1,8'd3 ,1,8'd13, 1,0,0, 0);
    add(0,1,8'd4 ,1,8'd14, 1,0,0, 0);
    add(0,1,8'd5 ,1,8'd15, 0,1,0, 2);

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_flags("reset_flags", 1'b0, 1'b0);
    check_mat("reset_data", zero_m);
    check_ovf("reset_ovf", 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      start       = vecs[k].st;
      in_valid[0] = vecs[k].v0;
      in_data[0]  = vecs[k].d0;
      in_valid[1] = vecs[k].v1;
      in_data[1]  = vecs[k].d1;
      @(posedge clk);
      #1;
      check_flags($sformatf("vec%0d_flags", k), vecs[k].eb, vecs[k].ed);
      check_ovf($sformatf("vec%0d_ovf", k), vecs[k].eo);
      if (vecs[k].chk == 2'd1) check_mat($sformatf("vec%0d_zero", k), zero_m);
      if (vecs[k].chk == 2'd2) check_mat($sformatf("vec%0d_matrix", k), ref_m);
    end

    // async reset between edges mid-collect
    start = 1'b1; in_valid = '0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 2'b11; in_data[0] = 8'd21; in_data[1] = 8'd31;
    @(posedge clk); #1;
    in_valid = '0;
    check_flags("pre_areset_flags", 1'b1, 1'b0);
    n_vec++;
    if (data_out[0][0] !== 8'd21 || data_out[0][1] !== 8'd31) begin
      n_err++;
      $display("FAIL pre_areset_row0: got %h/%h expected 15/1f", data_out[0][0], data_out[0][1]);
    end
    #2 reset = 1'b1;
    #1;
    check_flags("areset_flags", 1'b0, 1'b0);
    check_mat("areset_data", zero_m);
    check_ovf("areset_ovf", 1'b0);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
